// File: rtl/cond_logic.sv
// Condition evaluation and write-enable gating for the multicycle core.
// Holds NZCV, latches CondEx once per instruction, gates PC/RF/mem enables.
module cond_logic #(
    parameter int FLAGS_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         Cond,
    input  logic [FLAGS_W-1:0] ALUFlags,
    input  logic [1:0]         FlagW,
    input  logic               CondLatch,
    input  logic               PCS,
    input  logic               NextPC,
    input  logic               RegW,
    input  logic               MemW,
    output logic               PCWrite,
    output logic               RegWrite,
    output logic               MemWrite,
    output logic [FLAGS_W-1:0] Flags,
    output logic               CondEx
);

    logic [FLAGS_W-1:0] r_flags;
    logic               r_condex;
    logic               w_condcomb;
    logic               w_n;
    logic               w_z;
    logic               w_c;
    logic               w_v;

    assign {w_n, w_z, w_c, w_v} = r_flags;

    // Evaluated on the stored flags so a same-cycle flag write is not seen
    always_comb begin
        w_condcomb = 1'b1;
        case (Cond)
            4'b0000: w_condcomb = w_z;
            4'b0001: w_condcomb = ~w_z;
            4'b0010: w_condcomb = w_c;
            4'b0011: w_condcomb = ~w_c;
            4'b0100: w_condcomb = w_n;
            4'b0101: w_condcomb = ~w_n;
            4'b0110: w_condcomb = w_v;
            4'b0111: w_condcomb = ~w_v;
            4'b1000: w_condcomb = w_c & ~w_z;
            4'b1001: w_condcomb = ~w_c | w_z;
            4'b1010: w_condcomb = (w_n == w_v);
            4'b1011: w_condcomb = (w_n != w_v);
            4'b1100: w_condcomb = ~w_z & (w_n == w_v);
            4'b1101: w_condcomb = w_z | (w_n != w_v);
            4'b1110: w_condcomb = 1'b1;
            4'b1111: w_condcomb = 1'b1;
            default: w_condcomb = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_flags  <= '0;
            r_condex <= 1'b0;
        end else begin
            if (FlagW[1] & r_condex) r_flags[3:2] <= ALUFlags[3:2];
            if (FlagW[0] & r_condex) r_flags[1:0] <= ALUFlags[1:0];
            if (CondLatch)           r_condex     <= w_condcomb;
        end
    end

    assign PCWrite  = NextPC | (PCS & r_condex);
    assign RegWrite = RegW & r_condex;
    assign MemWrite = MemW & r_condex;
    assign Flags    = r_flags;
    assign CondEx   = r_condex;

endmodule

// File: tb/tb_cond_logic.sv
// Directed bench for cond_logic with a reference model and expectation queue.
module tb_cond_logic;

    logic       clk;
    logic       reset;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       CondLatch;
    logic       PCS;
    logic       NextPC;
    logic       RegW;
    logic       MemW;
    logic       PCWrite;
    logic       RegWrite;
    logic       MemWrite;
    logic [3:0] Flags;
    logic       CondEx;

    typedef struct {
        string      tag;
        logic [3:0] flags;
        logic       condex;
        logic       pcw;
        logic       rw;
        logic       mw;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    logic [3:0] m_flags;
    logic       m_condex;

    cond_logic #(.FLAGS_W(4)) dut (
        .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags),
        .FlagW(FlagW), .CondLatch(CondLatch), .PCS(PCS), .NextPC(NextPC),
        .RegW(RegW), .MemW(MemW), .PCWrite(PCWrite), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .Flags(Flags), .CondEx(CondEx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ARM encoding: Cond[3:1] picks the test, Cond[0] inverts it (not for AL)
    function automatic logic cond_ref(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cc, v, b;
        {n, z, cc, v} = f;
        case (c[3:1])
            3'd0:    b = z;
            3'd1:    b = cc;
            3'd2:    b = n;
            3'd3:    b = v;
            3'd4:    b = cc && !z;
            3'd5:    b = (n == v);
            3'd6:    b = !z && (n == v);
            default: b = 1'b1;
        endcase
        if (c[3:1] != 3'b111 && c[0]) b = !b;
        return b;
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic rst, input logic [3:0] c,
                        input logic [3:0] af, input logic [1:0] fw, input logic cl,
                        input logic pcs, input logic npc, input logic rw, input logic mw);
        exp_t       e;
        exp_t       o;
        logic [3:0] nf;
        logic       nce;
        reset = rst; Cond = c; ALUFlags = af; FlagW = fw;
        CondLatch = cl; PCS = pcs; NextPC = npc; RegW = rw; MemW = mw;
        if (!rst) begin
            nf  = 4'b0000;
            nce = 1'b0;
        end else begin
            nf = m_flags;
            if (fw[1] && m_condex) nf[3:2] = af[3:2];
            if (fw[0] && m_condex) nf[1:0] = af[1:0];
            nce = cl ? cond_ref(c, m_flags) : m_condex;
        end
        m_flags  = nf;
        m_condex = nce;
        e.tag    = tag;
        e.flags  = nf;
        e.condex = nce;
        e.pcw    = npc | (pcs & nce);
        e.rw     = rw & nce;
        e.mw     = mw & nce;
        sb.push_back(e);
        @(posedge clk);
        #1;
        total++;
        assert (sb.size() > 0) else begin
            bad++;
            $error("FAIL %s_sb obs=empty exp=entry", tag);
        end
        if (sb.size() > 0) begin
            o = sb.pop_front();
            check({o.tag, "_flags"}, Flags, o.flags);
            check({o.tag, "_condex"}, {3'b0, CondEx}, {3'b0, o.condex});
            check({o.tag, "_pcw"}, {3'b0, PCWrite}, {3'b0, o.pcw});
            check({o.tag, "_rw"}, {3'b0, RegWrite}, {3'b0, o.rw});
            check({o.tag, "_mw"}, {3'b0, MemWrite}, {3'b0, o.mw});
        end
    endtask

    // Latch AL, then load all four flags; leaves CondEx=1
    task automatic set_flags(input logic [3:0] f);
        step("set_al", 1, 4'b1110, 4'h0, 2'b00, 1, 0, 0, 0, 0);
        step("set_fl", 1, 4'b1110, f, 2'b11, 0, 0, 0, 0, 0);
    endtask

    task automatic point(input string tag, input logic [3:0] f,
                         input logic [3:0] c, input logic want);
        set_flags(f);
        step(tag, 1, c, 4'h0, 2'b00, 1, 0, 0, 0, 0);
        check({tag, "_const"}, {3'b0, CondEx}, {3'b0, want});
    endtask

    initial begin
        m_flags  = 4'b0000;
        m_condex = 1'b0;

        step("rst0", 0, 4'b1110, 4'hF, 2'b11, 1, 1, 0, 1, 1);
        step("rst1", 0, 4'b1110, 4'hF, 2'b11, 1, 1, 0, 1, 1);
        check("rst_const_flags", Flags, 4'b0000);
        check("rst_const_rw", {3'b0, RegWrite}, 4'b0000);

        step("upd_al", 1, 4'b1110, 4'h0, 2'b00, 1, 0, 0, 0, 0);
        step("upd_11", 1, 4'b1110, 4'b0110, 2'b11, 0, 0, 0, 0, 0);
        check("upd_const_0110", Flags, 4'b0110);
        step("upd_10", 1, 4'b1110, 4'b1001, 2'b10, 0, 0, 0, 0, 0);
        check("upd_const_1010", Flags, 4'b1010);

        for (int f = 0; f < 16; f++) begin
            set_flags(4'(f));
            for (int c = 0; c < 16; c++)
                step($sformatf("sw_f%0h_c%0h", f, c), 1, 4'(c), 4'h0,
                     2'b00, 1, 0, 0, 0, 0);
        end

        point("pt_ge", 4'b1001, 4'b1010, 1'b1);
        point("pt_lt", 4'b1000, 4'b1011, 1'b1);
        point("pt_hi1", 4'b0010, 4'b1000, 1'b1);
        point("pt_hi0", 4'b0110, 4'b1000, 1'b0);

        set_flags(4'b0000);
        step("fail_eq", 1, 4'b0000, 4'h0, 2'b00, 1, 0, 0, 0, 0);
        step("fail_gate", 1, 4'b0000, 4'hF, 2'b11, 0, 1, 0, 1, 1);
        check("fail_const_flags", Flags, 4'b0000);
        check("fail_const_pcw", {3'b0, PCWrite}, 4'b0000);
        step("fail_npc", 1, 4'b0000, 4'hF, 2'b11, 0, 1, 1, 1, 1);
        check("fail_const_npc", {3'b0, PCWrite}, 4'b0001);

        set_flags(4'b0000);
        step("haz", 1, 4'b0000, 4'b0100, 2'b11, 1, 0, 0, 0, 0);
        check("haz_const_flags", Flags, 4'b0100);
        check("haz_const_condex", {3'b0, CondEx}, 4'b0000);
        step("haz_re", 1, 4'b0000, 4'h0, 2'b00, 1, 0, 0, 0, 0);
        check("haz_const_re", {3'b0, CondEx}, 4'b0001);

        step("hold_al", 1, 4'b1110, 4'h0, 2'b00, 1, 0, 0, 0, 0);
        step("hold1", 1, 4'b0000, 4'b0000, 2'b11, 0, 0, 0, 1, 0);
        step("hold2", 1, 4'b0000, 4'b1111, 2'b11, 0, 0, 0, 0, 1);
        step("hold3", 1, 4'b0000, 4'b0101, 2'b01, 0, 1, 0, 1, 0);
        check("hold_const_condex", {3'b0, CondEx}, 4'b0001);

        step("mid_rst", 0, 4'b1110, 4'hF, 2'b11, 0, 1, 1, 1, 1);
        step("mid_after", 1, 4'b1110, 4'hF, 2'b11, 0, 1, 1, 1, 1);
        check("mid_const_rw", {3'b0, RegWrite}, 4'b0000);
        check("mid_const_pcw", {3'b0, PCWrite}, 4'b0001);

        total++;
        assert (sb.size() == 0) else begin
            bad++;
            $error("FAIL sb_drain obs=%0d exp=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
